// File: rtl/four_12_12_tap_wr_arb_if.sv
// Bus bundle for the tap-memory write arbiter: error sub-writes, writeback
// handshake, flush, read-hazard query and the tap memory write port.
interface four_12_12_tap_wr_arb_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 384
);
    logic              err_vld;
    logic [3:0]        err_phase;
    logic [31:0]       err_sub_addr;
    logic [31:0]       err_sub_data;
    logic              upd_vld;
    logic              upd_rdy;
    logic [ADDR_W-1:0] upd_addr;
    logic [DATA_W-1:0] upd_data;
    logic              flush;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_hazard;
    logic              mem_wr_vld;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_sub_vld;
    logic [31:0]       mem_sub_addr;
    logic [31:0]       mem_sub_data;
    logic [2:0]        fifo_level;

    modport slave (
        input  err_vld, err_phase, err_sub_addr, err_sub_data,
        input  upd_vld, upd_addr, upd_data, flush, rd_addr,
        output upd_rdy, rd_hazard, fifo_level,
        output mem_wr_vld, mem_wr_addr, mem_wr_data, mem_sub_vld, mem_sub_addr, mem_sub_data
    );

    modport master (
        output err_vld, err_phase, err_sub_addr, err_sub_data,
        output upd_vld, upd_addr, upd_data, flush, rd_addr,
        input  upd_rdy, rd_hazard, fifo_level,
        input  mem_wr_vld, mem_wr_addr, mem_wr_data, mem_sub_vld, mem_sub_addr, mem_sub_data
    );
endinterface

// File: rtl/four_12_12_tap_wr_arb.sv
// Tap memory write-port arbiter: error sub-writes win, queued row writebacks fill idle slots.
// Optional macro TAP_WR_ARB_STATS_EN adds a saturating pop-deferral counter (stall_cnt).
module four_12_12_tap_wr_arb #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 384,
    parameter int FIFO_DEPTH = 4,
    parameter int TAP_BASE   = 12
) (
    input logic clk,
    input logic reset,
    four_12_12_tap_wr_arb_if.slave bus
`ifdef TAP_WR_ARB_STATS_EN
    ,
    output logic [15:0] stall_cnt
`endif
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              vld_p1;
    logic              sub_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] data_p1;
    logic [31:0]       sub_addr_p1;
    logic [31:0]       sub_data_p1;

    logic [ADDR_W-1:0] err_addr;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              hazard;

    // Sum truncates to ADDR_W bits so the error row address wraps.
    assign err_addr = ADDR_W'(TAP_BASE) + ADDR_W'(bus.err_phase);
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign push     = bus.upd_vld && !full && !bus.flush;
    assign pop      = !bus.err_vld && !empty && !bus.flush;

    assign bus.upd_rdy      = !full;
    assign bus.fifo_level   = 3'(count);
    assign bus.mem_wr_vld   = vld_p1;
    assign bus.mem_sub_vld  = sub_p1;
    assign bus.mem_wr_addr  = addr_p1;
    assign bus.mem_wr_data  = data_p1;
    assign bus.mem_sub_addr = sub_addr_p1;
    assign bus.mem_sub_data = sub_data_p1;
    assign bus.rd_hazard    = hazard;

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if ((CNT_W'(i) < count) && (addr_q[rd_ptr + PTR_W'(i)] == bus.rd_addr))
                hazard = 1'b1;
        end
        if (vld_p1 && (addr_p1 == bus.rd_addr))
            hazard = 1'b1;
        if (bus.err_vld && (err_addr == bus.rd_addr))
            hazard = 1'b1;
    end

    // FIFO storage carries no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= bus.upd_addr;
            data_q[wr_ptr] <= bus.upd_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Output stage p1: one registered write per edge, error sub-write first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1      <= 1'b0;
            sub_p1      <= 1'b0;
            addr_p1     <= '0;
            data_p1     <= '0;
            sub_addr_p1 <= '0;
            sub_data_p1 <= '0;
        end else if (bus.err_vld) begin
            vld_p1      <= 1'b1;
            sub_p1      <= 1'b1;
            addr_p1     <= err_addr;
            sub_addr_p1 <= bus.err_sub_addr;
            sub_data_p1 <= bus.err_sub_data;
        end else if (pop) begin
            vld_p1  <= 1'b1;
            sub_p1  <= 1'b0;
            addr_p1 <= addr_q[rd_ptr];
            data_p1 <= data_q[rd_ptr];
        end else begin
            vld_p1 <= 1'b0;
            sub_p1 <= 1'b0;
        end
    end

`ifdef TAP_WR_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (bus.flush)
            stall_cnt <= '0;
        else if (bus.err_vld && !empty && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule
